// File: rtl/i2s_pkg.sv
// Shared types and sizing helpers for the I2S transmit scheduler.
// Holds the state encoding, default widths and counter widths.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SLOT_W   = 32;
    localparam int DEF_BCLK_DIV = 16;

    function automatic int div_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic int bit_w(input int slot);
        return $clog2(2 * slot);
    endfunction

endpackage

// File: rtl/i2s_tx_scheduler_bclk_gen.sv
// Bit-clock divider with synchronous restart.
// Rise/fall strobes flag the clk cycle in which registered bclk toggles.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic bclk,
    output logic rise,
    output logic fall
);

    localparam int CW = div_w(BCLK_DIV);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = run && !restart && (cnt == CW'(BCLK_DIV - 1));
    assign rise = tick && !bclk;
    assign fall = tick && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (restart || !run) begin
            cnt  <= '0;
            bclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            bclk <= ~bclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_scheduler.sv
// I2S transmit scheduler: one-entry sample buffer, BCLK/LRCLK generation,
// MSB-first frame shifting with priming, underrun, mute and aligned stop.
module i2s_tx_scheduler
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SLOT_W   = DEF_SLOT_W,
    parameter int BCLK_DIV = DEF_BCLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mute,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun
);

    localparam int FW = 2 * SLOT_W;
    localparam int BW = bit_w(SLOT_W);

    state_t            state_q, state_d;
    logic              hold_valid, hv_d, s_ready_d;
    logic [DATA_W-1:0] hold_l, hold_r, src_l, src_r;
    logic [FW-1:0]     shreg, word;
    logic [BW-1:0]     b, b_inc;
    logic              hs, wrap, load, restart, starve, lr_d, bclk_run;
    logic              fall, rise_unused;

    i2s_bclk_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_bclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .run    (bclk_run),
        .bclk   (bclk),
        .rise   (rise_unused),
        .fall   (fall)
    );

    assign bclk_run = (state_q == RUN) || (state_q == STOP);
    assign hs       = s_valid && s_ready;
    assign wrap     = fall && (b == BW'(FW - 1));
    assign starve   = !hold_valid && !hs;
    assign b_inc    = b + 1'b1;
    // lrclk leads data by one bit, so it flips one slot position early
    assign lr_d     = (b_inc >= BW'(SLOT_W - 1)) && (b_inc <= BW'(FW - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            IDLE: if (enable) state_d = PRIME;
            PRIME: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (hs) begin
                    state_d = RUN;
                    load    = 1'b1;
                    restart = 1'b1;
                end
            end
            RUN: begin
                if (wrap) begin
                    if (!enable) state_d = IDLE;
                    else         load    = 1'b1;
                end else if (!enable) begin
                    state_d = STOP;
                end
            end
            STOP: if (wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE || load) hv_d = 1'b0;
        else if (hs)                 hv_d = 1'b1;
        else                         hv_d = hold_valid;

        s_ready_d = (state_d == PRIME) || ((state_d == RUN) && !hv_d);
    end

    // Buffered pair wins; otherwise the incoming pair bypasses the buffer
    always_comb begin
        src_l = hold_valid ? hold_l : s_left;
        src_r = hold_valid ? hold_r : s_right;
        word  = (FW'(src_l) << (FW - DATA_W)) |
                (FW'(src_r) << (SLOT_W - DATA_W));
        if (mute || starve) word = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid  <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            shreg       <= '0;
            b           <= '0;
            lrclk       <= 1'b0;
            sdata       <= 1'b0;
            s_ready     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            hold_valid  <= hv_d;
            s_ready     <= s_ready_d;
            frame_start <= load;
            underrun    <= load && starve;
            if (hs && !load) begin
                hold_l <= s_left;
                hold_r <= s_right;
            end
            if (state_d == IDLE) begin
                shreg <= '0;
                b     <= '0;
                lrclk <= 1'b0;
                sdata <= 1'b0;
            end else if (load) begin
                shreg <= word << 1;
                sdata <= word[FW-1];
                b     <= '0;
                lrclk <= 1'b0;
            end else if (fall) begin
                shreg <= shreg << 1;
                sdata <= shreg[FW-1];
                b     <= b_inc;
                lrclk <= lr_d;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler: default build plus a 24-bit,
// fast-BCLK build, with frames captured on bclk rising edges.
module tb_i2s_tx_scheduler;

    localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        mute = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_left = '0;
    logic [31:0] s_right = '0;
    logic        s_ready, bclk, lrclk, sdata, frame_start, underrun;

    logic        en24 = 1'b0;
    logic        v24 = 1'b0;
    logic [23:0] l24 = '0;
    logic [23:0] r24 = '0;
    logic        rdy24, bclk24, lr24, sd24, fs24, ur24;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;

    i2s_tx_scheduler u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mute       (mute),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    i2s_tx_scheduler #(
        .DATA_W  (24),
        .SLOT_W  (32),
        .BCLK_DIV(2)
    ) u_d24 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (en24),
        .mute       (1'b0),
        .s_valid    (v24),
        .s_ready    (rdy24),
        .s_left     (l24),
        .s_right    (r24),
        .bclk       (bclk24),
        .lrclk      (lr24),
        .sdata      (sd24),
        .frame_start(fs24),
        .underrun   (ur24)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [63:0] p;
        if (q.size() > 0) begin
            p       = q[0];
            s_valid = 1'b1;
            s_left  = p[63:32];
            s_right = p[31:0];
        end else begin
            s_valid = 1'b0;
        end
    endtask

    task automatic push(input logic [63:0] p);
        q.push_back(p);
        drive();
    endtask

    task automatic tick();
        logic hs;
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) void'(q.pop_front());
        drive();
    endtask

    // act 1: raise mute, act 2: drop enable, once act_k bits have been seen
    task automatic cap(input int act_k, input int act,
                       output logic [63:0] d, output logic [63:0] lr);
        int   k;
        int   cyc;
        logic pb;
        k   = 0;
        cyc = 0;
        pb  = bclk;
        d   = '0;
        lr  = '0;
        while (k < 64 && cyc < 4000) begin
            if (k == act_k && act == 1) mute = 1'b1;
            if (k == act_k && act == 2) enable = 1'b0;
            tick();
            cyc++;
            if (bclk && !pb) begin
                d[63-k]  = sdata;
                lr[63-k] = lrclk;
                k++;
            end
            pb = bclk;
        end
        chk("cap_rises", 64'(k), 64'd64);
    endtask

    task automatic wait_load(output logic ur);
        int cyc;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!frame_start && cyc < 4000);
        chk("load_seen", 64'(frame_start), 64'd1);
        ur = underrun;
    endtask

    initial begin
        logic [63:0] d, lr;
        logic        ur, pb;
        int          k, cyc, fs_cnt, bc, first, second;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", 64'({bclk, lrclk, sdata, s_ready, frame_start, underrun}), 64'd0);
        chk("reset_out24", 64'({bclk24, lr24, sd24, rdy24, fs24, ur24}), 64'd0);
        rst_n = 1'b1;

        // basic frame
        enable = 1'b1;
        tick();
        chk("prime_ready", 64'(s_ready), 64'd1);
        repeat (3) tick();
        chk("prime_ready_hold", 64'(s_ready), 64'd1);
        push({32'hA5A5_0001, 32'h8000_0000});
        tick();
        chk("first_sdata", 64'(sdata), 64'd1);
        chk("first_lrclk", 64'(lrclk), 64'd0);
        chk("first_fs", 64'(frame_start), 64'd1);
        chk("first_bclk", 64'(bclk), 64'd0);
        cap(-1, 0, d, lr);
        chk("basic_frame", d, {32'hA5A5_0001, 32'h8000_0000});
        chk("basic_lrclk", lr, LR_EXP);

        // underrun
        wait_load(ur);
        chk("ur_pulse", 64'(ur), 64'd1);
        cap(-1, 0, d, lr);
        chk("ur_frame", d, 64'd0);
        chk("ur_lrclk", lr, LR_EXP);

        // backpressure and bypass in the load cycle
        repeat (15) tick();
        for (int i = 1; i <= 8; i++) q.push_back({32'(i), 32'hC000_0000 + 32'(i)});
        drive();
        tick();
        chk("bypass_fs", 64'(frame_start), 64'd1);
        chk("bypass_ur", 64'(underrun), 64'd0);
        tick();
        chk("full_ready", 64'(s_ready), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            if (i > 1) begin
                wait_load(ur);
                chk("bp_ur", 64'(ur), 64'd0);
            end
            cap(-1, 0, d, lr);
            chk("bp_frame", d, {32'(i), 32'hC000_0000 + 32'(i)});
        end
        wait_load(ur);
        chk("bp_drained_ur", 64'(ur), 64'd1);
        chk("bp_queue_empty", 64'(q.size()), 64'd0);

        // mute
        push({32'h1234_5678, 32'h9ABC_DEF0});
        push({32'hFFFF_FFFF, 32'hFFFF_FFFF});
        wait_load(ur);
        chk("mute_pre_ur", 64'(ur), 64'd0);
        cap(32, 1, d, lr);
        chk("mute_cur_frame", d, {32'h1234_5678, 32'h9ABC_DEF0});
        wait_load(ur);
        chk("mute_ur", 64'(ur), 64'd0);
        cap(-1, 0, d, lr);
        chk("mute_frame", d, 64'd0);
        mute = 1'b0;
        wait_load(ur);
        chk("mute_consumed", 64'(ur), 64'd1);

        // stop
        push({32'h0F0F_0F0F, 32'h1234_5679});
        wait_load(ur);
        chk("stop_pre_ur", 64'(ur), 64'd0);
        cap(10, 2, d, lr);
        chk("stop_frame", d, {32'h0F0F_0F0F, 32'h1234_5679});
        chk("stop_lrclk", lr, LR_EXP);
        cyc = 0;
        while (bclk && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("stop_out", 64'({bclk, lrclk, sdata, frame_start, underrun, s_ready}), 64'd0);
        fs_cnt = 0;
        bc     = 0;
        repeat (200) begin
            tick();
            fs_cnt += int'(frame_start);
            bc     += int'(bclk);
        end
        chk("stop_idle_fs", 64'(fs_cnt), 64'd0);
        chk("stop_idle_bclk", 64'(bc), 64'd0);

        // reset mid-frame
        enable = 1'b1;
        repeat (2) tick();
        push({32'hDEAD_BEEF, 32'hFFFF_FFFF});
        tick();
        k   = 0;
        cyc = 0;
        pb  = bclk;
        while (k < 41 && cyc < 4000) begin
            tick();
            cyc++;
            if (bclk && !pb) k++;
            pb = bclk;
        end
        chk("rst_pre_lr_sd", 64'({lrclk, sdata}), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_out", 64'({bclk, lrclk, sdata, s_ready, frame_start, underrun}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_prime", 64'({s_ready, bclk, frame_start}), 64'b100);
        push({32'h8765_4321, 32'h0FED_CBA9});
        tick();
        chk("rst_restart", 64'({frame_start, sdata}), 64'b11);
        cap(-1, 0, d, lr);
        chk("rst_frame", d, {32'h8765_4321, 32'h0FED_CBA9});

        // 24-bit samples, 4-clk BCLK
        en24 = 1'b1;
        tick();
        chk("d24_prime", 64'(rdy24), 64'd1);
        l24 = 24'hFF_FFFF;
        r24 = 24'h80_0001;
        v24 = 1'b1;
        tick();
        v24 = 1'b0;
        chk("d24_first", 64'({fs24, sd24}), 64'b11);
        k      = 0;
        cyc    = 0;
        pb     = bclk24;
        first  = -1;
        second = -1;
        d      = '0;
        while (k < 64 && cyc < 1000) begin
            tick();
            cyc++;
            if (bclk24 && !pb) begin
                d[63-k] = sd24;
                if (k == 0) first = cyc;
                if (k == 1) second = cyc;
                k++;
            end
            pb = bclk24;
        end
        chk("d24_rises", 64'(k), 64'd64);
        chk("d24_frame", d, 64'hFFFF_FF00_8000_0100);
        chk("d24_first_rise", 64'(first), 64'd2);
        chk("d24_period", 64'(second - first), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
